// File: rtl/playback_sequencer_pkg.sv
// Shared definitions for the music-player transport: state encodings,
// BCD digit width, the note ROM end marker and the song-index stepper.
package playback_sequencer_pkg;

  // Transport state; the display top decodes the same encodings.
  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } play_state_e;

  localparam int BCD_W  = 4;
  localparam int NOTE_W = 8;

  // Note code stored in the ROM after the last note of each song.
  localparam logic [NOTE_W-1:0] END_MARKER = 8'hFF;

  // Step a song index up or down by one, wrapping within 0..songs-1.
  function automatic logic [1:0] song_step(input logic [1:0] cur,
                                           input logic       up,
                                           input int         songs);
    logic [1:0] last;
    last = 2'(songs - 1);
    if (up) begin
      if (cur == last) begin
        song_step = 2'd0;
      end else begin
        song_step = cur + 2'd1;
      end
    end else begin
      if (cur == 2'd0) begin
        song_step = last;
      end else begin
        song_step = cur - 2'd1;
      end
    end
  endfunction

endpackage

// File: rtl/playback_sequencer_bcd_elapsed_timer.sv
// Elapsed play time: a sub-second tick divider feeding an mm:ss BCD counter
// that counts 00:00..99:59 and then sticks at 99:59.
module bcd_elapsed_timer
  import playback_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [BCD_W-1:0] bcd3,
  output logic [BCD_W-1:0] bcd2,
  output logic [BCD_W-1:0] bcd1,
  output logic [BCD_W-1:0] bcd0
);

  // A divider of one still needs a one-bit counter that is always at its last value.
  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [BCD_W-1:0] m1_q, m1_d;
  logic [BCD_W-1:0] m0_q, m0_d;
  logic [BCD_W-1:0] s1_q, s1_d;
  logic [BCD_W-1:0] s0_q, s0_d;
  logic             at_max;

  assign at_max = (m1_q == 4'd9) && (m0_q == 4'd9) && (s1_q == 4'd5) && (s0_q == 4'd9);

  // Next-state for the divider and the ripple-carry BCD digits.
  always_comb begin
    sub_d = sub_q;
    m1_d  = m1_q;
    m0_d  = m0_q;
    s1_d  = s1_q;
    s0_d  = s0_q;
    if (clear) begin
      sub_d = {SUB_W{1'b0}};
      m1_d  = 4'd0;
      m0_d  = 4'd0;
      s1_d  = 4'd0;
      s0_d  = 4'd0;
    end else if (inc) begin
      if (sub_q == SUB_LAST) begin
        sub_d = {SUB_W{1'b0}};
        if (at_max) begin
          s0_d = s0_q;
        end else if (s0_q != 4'd9) begin
          s0_d = s0_q + 4'd1;
        end else begin
          s0_d = 4'd0;
          if (s1_q != 4'd5) begin
            s1_d = s1_q + 4'd1;
          end else begin
            s1_d = 4'd0;
            if (m0_q != 4'd9) begin
              m0_d = m0_q + 4'd1;
            end else begin
              m0_d = 4'd0;
              m1_d = m1_q + 4'd1;
            end
          end
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end else begin
      sub_d = sub_q;
    end
  end

  // Time registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub_q <= {SUB_W{1'b0}};
      m1_q  <= 4'd0;
      m0_q  <= 4'd0;
      s1_q  <= 4'd0;
      s0_q  <= 4'd0;
    end else begin
      sub_q <= sub_d;
      m1_q  <= m1_d;
      m0_q  <= m0_d;
      s1_q  <= s1_d;
      s0_q  <= s0_d;
    end
  end

  assign bcd3 = m1_q;
  assign bcd2 = m0_q;
  assign bcd1 = s1_q;
  assign bcd0 = s0_q;

endmodule

// File: rtl/playback_sequencer.sv
// Transport controller: STOP/PLAY/PAUSE state, song selection and note-ROM
// address, advanced on beat ticks, with an mm:ss elapsed-time readout.
// SONGS is expected in 2..4 and TICKS_PER_SEC >= 1.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int SONGS         = 4,
  parameter int TICKS_PER_SEC = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              stop,
  input  logic              next,
  input  logic              prev,
  input  logic              beat_tick,
  input  logic              song_end,
  input  logic              repeat_en,
  output logic [1:0]        state,
  output logic [1:0]        song_sel,
  output logic [ADDR_W-1:0] note_addr,
  output logic              mute,
  output logic [BCD_W-1:0]  BCD3,
  output logic [BCD_W-1:0]  BCD2,
  output logic [BCD_W-1:0]  BCD1,
  output logic [BCD_W-1:0]  BCD0
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  play_state_e       state_q, state_d;
  logic [1:0]        song_q, song_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mute_q, mute_d;
  logic              nav_one;
  logic              rewind;
  logic              time_inc;

  // Exactly one of next/prev; both together cancel and fall through.
  assign nav_one = next ^ prev;

  // Prioritised event decode: stop > next/prev > play_pause > beat_tick.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    addr_d   = addr_q;
    rewind   = 1'b0;
    time_inc = 1'b0;
    if (stop) begin
      state_d = STOP;
      rewind  = 1'b1;
    end else if (nav_one) begin
      song_d = song_step(song_q, next, SONGS);
      rewind = 1'b1;
    end else if (play_pause) begin
      case (state_q)
        STOP:    state_d = PLAY;
        PLAY:    state_d = PAUSE;
        PAUSE:   state_d = PLAY;
        default: state_d = STOP;
      endcase
    end else if (beat_tick && (state_q == PLAY)) begin
      // The last address is treated as an implicit end marker.
      if (song_end || (addr_q == ADDR_LAST)) begin
        rewind = 1'b1;
        if (repeat_en) begin
          state_d = PLAY;
        end else begin
          state_d = STOP;
        end
      end else begin
        addr_d   = addr_q + ADDR_W'(1);
        time_inc = 1'b1;
      end
    end else begin
      state_d = state_q;
    end

    if (rewind) begin
      addr_d = {ADDR_W{1'b0}};
    end else begin
      addr_d = addr_d;
    end

    mute_d = (state_d != PLAY);
  end

  // Transport FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= STOP;
      song_q  <= 2'd0;
      addr_q  <= {ADDR_W{1'b0}};
      mute_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      addr_q  <= addr_d;
      mute_q  <= mute_d;
    end
  end

  bcd_elapsed_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .inc  (time_inc),
    .clear(rewind),
    .bcd3 (BCD3),
    .bcd2 (BCD2),
    .bcd1 (BCD1),
    .bcd0 (BCD0)
  );

  assign state     = state_q;
  assign song_sel  = song_q;
  assign note_addr = addr_q;
  assign mute      = mute_q;

endmodule
